// File: rtl/load_unit_mc.sv
// load_unit_mc: multi-cycle byte/half/word load unit behind a valid/ready memory request channel.
// Define LOAD_TIMEOUT_EN to abort a request that sees no response within TIMEOUT_CYC cycles.
module load_unit_mc #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] out,
    output logic              err,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_data
);
    localparam int LANE_W = $clog2(DATA_W / 8);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    if (DATA_W < 16 || (DATA_W & (DATA_W - 1)) != 0 || TIMEOUT_CYC < 1) begin : g_bad_params
        $error("load_unit_mc: unsupported parameter set");
    end

    // Access is illegal for the reserved size or when the field is not naturally aligned.
    function automatic logic f_illegal(input logic [1:0] sz, input logic [LANE_W-1:0] lane);
        logic bad;
        case (sz)
            2'b00:   bad = 1'b0;
            2'b01:   bad = lane[0];
            2'b10:   bad = (lane != {LANE_W{1'b0}});
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [DATA_W-1:0] f_extract(input logic [DATA_W-1:0] data,
                                                     input logic [LANE_W-1:0] lane,
                                                     input logic [1:0]        sz,
                                                     input logic              sx);
        logic [DATA_W-1:0] shifted;
        logic [DATA_W-1:0] res;
        shifted = data >> {lane, 3'b000};
        case (sz)
            2'b00: begin
                res       = {DATA_W{sx & shifted[7]}};
                res[7:0]  = shifted[7:0];
            end
            2'b01: begin
                res       = {DATA_W{sx & shifted[15]}};
                res[15:0] = shifted[15:0];
            end
            default: res = data;
        endcase
        return res;
    endfunction

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [LANE_W-1:0] r_lane;
    logic [1:0]        r_size;
    logic              r_sign;
    logic [DATA_W-1:0] r_out;
    logic              r_err;
    logic              r_done;

    logic [1:0]        w_next_state;
    logic              w_take;
    logic              w_fail;
    logic              w_illegal_in;
    logic [DATA_W-1:0] w_extract;

    assign w_illegal_in = f_illegal(size, addr_in[LANE_W-1:0]);
    assign w_extract    = f_extract(mem_rsp_data, r_lane, r_size, r_sign);

`ifdef LOAD_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;

    logic [CNT_W-1:0] r_cnt;
    logic             w_timeout;

    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYC));

    // Wait counter: zero outside REQ/WAIT, so it starts at zero on entry to REQ.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (r_state == S_REQ || r_state == S_WAIT) begin
            r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_cnt <= {CNT_W{1'b0}};
        end
    end
`endif

    // Next-state decode plus the take-data / fail qualifiers for the result registers.
    always_comb begin
        w_next_state = r_state;
        w_take       = 1'b0;
        w_fail       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (w_illegal_in) begin
                        w_next_state = S_DONE;
                        w_fail       = 1'b1;
                    end else begin
                        w_next_state = S_REQ;
                    end
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_REQ: begin
`ifdef LOAD_TIMEOUT_EN
                if (w_timeout) begin
                    w_next_state = S_DONE;
                    w_fail       = 1'b1;
                end else if (mem_req_ready) begin
                    w_next_state = S_WAIT;
                end else begin
                    w_next_state = S_REQ;
                end
`else
                if (mem_req_ready) begin
                    w_next_state = S_WAIT;
                end else begin
                    w_next_state = S_REQ;
                end
`endif
            end
            S_WAIT: begin
                // A response in the expiry cycle still wins over the timeout.
                if (mem_rsp_valid) begin
                    w_next_state = S_DONE;
                    w_take       = 1'b1;
`ifdef LOAD_TIMEOUT_EN
                end else if (w_timeout) begin
                    w_next_state = S_DONE;
                    w_fail       = 1'b1;
`endif
                end else begin
                    w_next_state = S_WAIT;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // State, captured request fields and the registered result/done outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_addr  <= {ADDR_W{1'b0}};
            r_lane  <= {LANE_W{1'b0}};
            r_size  <= 2'b00;
            r_sign  <= 1'b0;
            r_out   <= {DATA_W{1'b0}};
            r_err   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_done  <= (w_next_state == S_DONE);
            if (r_state == S_IDLE && start) begin
                r_addr <= {addr_in[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
                r_lane <= addr_in[LANE_W-1:0];
                r_size <= size;
                r_sign <= sign_ext;
            end
            if (w_take) begin
                r_out <= w_extract;
                r_err <= 1'b0;
            end else if (w_fail) begin
                r_out <= {DATA_W{1'b0}};
                r_err <= 1'b1;
            end
        end
    end

    assign busy          = (r_state != S_IDLE);
    assign mem_req_valid = (r_state == S_REQ);
    assign mem_addr      = r_addr;
    assign done          = r_done;
    assign out           = r_out;
    assign err           = r_err;

endmodule

// File: tb/tb_load_unit_mc.sv
// Directed bench for load_unit_mc: spec-level model plus scoreboard checked on every done pulse.
module tb_load_unit_mc;
    localparam int DW = 16;
    localparam int AW = 16;
    localparam int TO = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] addr_in = 16'h0000;
    logic [1:0]    size = 2'b00;
    logic          sign_ext = 1'b0;
    logic          busy, done, err, mem_req_valid;
    logic [DW-1:0] out;
    logic [AW-1:0] mem_addr;
    logic          mem_req_ready = 1'b0;
    logic          mem_rsp_valid = 1'b0;
    logic [DW-1:0] mem_rsp_data = 16'h0000;

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [31:0] cyc;
        logic [15:0] out;
        logic        err;
        logic        chk_out;
    } exp_t;

    exp_t sb[$];
    exp_t cmp_e;

    load_unit_mc #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT_CYC(TO)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .addr_in       (addr_in),
        .size          (size),
        .sign_ext      (sign_ext),
        .busy          (busy),
        .done          (done),
        .out           (out),
        .err           (err),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_addr      (mem_addr),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Spec rules: little-endian lane select, then zero/sign extension to 16 bits.
    function automatic logic [15:0] m_result(input logic [15:0] a, input logic [1:0] sz,
                                             input logic sx, input logic [15:0] d);
        int lane;
        int v;
        lane = int'(a) % 2;
        v    = int'(d);
        if (sz == 2'd0) begin
            v = (v >> (8 * lane)) % 256;
            if (sx && v >= 128) v = v + 65536 - 256;
        end else if (sz == 2'd1) begin
            v = (v >> (8 * lane)) % 65536;
        end
        return v[15:0];
    endfunction

    function automatic bit m_illegal(input logic [15:0] a, input logic [1:0] sz);
        int lane;
        lane = int'(a) % 2;
        return (sz == 2'd3) || (sz == 2'd1 && lane % 2 != 0) || (sz == 2'd2 && lane != 0);
    endfunction

    function automatic bit m_timed_out(input int d, input int r);
`ifdef LOAD_TIMEOUT_EN
        return (r < 0) || (d + r + 1 > TO);
`else
        return (r < 0);
`endif
    endfunction

    // Cycles from start to done: start, d stall cycles, accept, r idle wait cycles, response.
    function automatic int m_latency(input int d, input int r);
        if (m_timed_out(d, r)) return TO + 2;
        return 3 + d + r;
    endfunction

    task automatic run_load(input logic [15:0] a, input logic [1:0] sz, input logic sx,
                            input int d, input int r, input logic [15:0] data, input bit poke);
        exp_t        e;
        bit          ill;
        bit          tmo;
        int          g;
        logic [15:0] aligned;
        ill     = m_illegal(a, sz);
        aligned = a & 16'hFFFE;
        start = 1'b1; addr_in = a; size = sz; sign_ext = sx;
        @(posedge clk); #1;
        start = 1'b0; addr_in = 16'hFFFF; size = 2'b11; sign_ext = ~sx;
        tmo       = !ill && m_timed_out(d, r);
        e.cyc     = 32'(cyc + (ill ? 1 : m_latency(d, r)) - 1);
        e.err     = ill || tmo;
        e.out     = (ill || tmo) ? 16'h0000 : m_result(a, sz, sx, data);
        e.chk_out = !ill;
        sb.push_back(e);
        if (!ill) begin
            for (int k = 0; k < d; k++) begin
                chk("stall_req_valid", {31'd0, mem_req_valid}, 32'd1);
                chk("stall_mem_addr", {16'd0, mem_addr}, {16'd0, aligned});
                if (poke && k == 0) begin
                    start = 1'b1; addr_in = 16'h1235; size = 2'b00;
                end
                @(posedge clk); #1;
                start = 1'b0;
            end
            chk("req_valid", {31'd0, mem_req_valid}, 32'd1);
            chk("req_mem_addr", {16'd0, mem_addr}, {16'd0, aligned});
            mem_req_ready = 1'b1; mem_rsp_valid = 1'b1; mem_rsp_data = ~data;
            @(posedge clk); #1;
            mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
            if (r >= 0) begin
                for (int k = 0; k < r; k++) begin
                    chk("wait_req_valid_low", {31'd0, mem_req_valid}, 32'd0);
                    @(posedge clk); #1;
                end
                mem_rsp_valid = 1'b1; mem_rsp_data = data;
                @(posedge clk); #1;
                mem_rsp_valid = 1'b0; mem_rsp_data = 16'h0000;
            end
        end
        g = 0;
        while (done !== 1'b1 && g < 300) begin
            @(posedge clk); #1;
            g++;
        end
        chk("done_seen", {31'd0, done}, 32'd1);
        if (done !== 1'b1) sb.delete();
        @(posedge clk); #1;
        chk("idle_after_done", {31'd0, busy}, 32'd0);
    endtask

    // Scoreboard compare on every done pulse; any done with nothing pending is an error.
    always @(negedge clk) begin
        if (rst_n && done === 1'b1) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_done: done=1 at cycle %0d, required done=0", cyc);
            end else begin
                cmp_e = sb.pop_front();
                chk("done_cycle", cyc, cmp_e.cyc);
                chk("err", {31'd0, err}, {31'd0, cmp_e.err});
                if (cmp_e.chk_out) chk("out", {16'd0, out}, {16'd0, cmp_e.out});
                chk("busy_in_done", {31'd0, busy}, 32'd1);
                chk("req_valid_in_done", {31'd0, mem_req_valid}, 32'd0);
            end
        end
    end

    initial begin
        #12;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_out", {16'd0, out}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_req_valid", {31'd0, mem_req_valid}, 32'd0);
        chk("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        chk("model_byte_sx", {16'd0, m_result(16'h0041, 2'b00, 1'b1, 16'h80FF)}, 32'h0000FF80);
        chk("model_byte_zx", {16'd0, m_result(16'h0041, 2'b00, 1'b0, 16'h80FF)}, 32'h00000080);
        chk("model_word", {16'd0, m_result(16'h0040, 2'b10, 1'b1, 16'hBEEF)}, 32'h0000BEEF);
        chk("model_illegal_half", {31'd0, m_illegal(16'h0043, 2'b01)}, 32'd1);
        chk("model_latency", m_latency(0, 0), 32'd3);

        run_load(16'h0040, 2'b10, 1'b0, 0, 0, 16'hBEEF, 1'b0);
        chk("full_word_out", {16'd0, out}, 32'h0000BEEF);
        run_load(16'h0041, 2'b00, 1'b1, 0, 0, 16'h80FF, 1'b0);
        chk("byte_sx_out", {16'd0, out}, 32'h0000FF80);
        run_load(16'h0041, 2'b00, 1'b0, 0, 0, 16'h80FF, 1'b0);
        chk("byte_zx_out", {16'd0, out}, 32'h00000080);
        run_load(16'h0040, 2'b00, 1'b1, 0, 1, 16'h1234, 1'b0);
        run_load(16'h00A0, 2'b00, 1'b1, 0, 0, 16'h12A5, 1'b0);
        chk("byte_lane0_sx_out", {16'd0, out}, 32'h0000FFA5);
        run_load(16'h0042, 2'b01, 1'b1, 0, 0, 16'h8001, 1'b0);
        run_load(16'h0042, 2'b01, 1'b0, 0, 0, 16'h7FFE, 1'b0);

        run_load(16'h0043, 2'b01, 1'b0, 0, 0, 16'h0000, 1'b0);
        chk("illegal_half_err", {31'd0, err}, 32'd1);
        run_load(16'h0040, 2'b11, 1'b0, 0, 0, 16'h0000, 1'b0);
        run_load(16'h0045, 2'b10, 1'b0, 0, 0, 16'h0000, 1'b0);

        run_load(16'h1236, 2'b10, 1'b0, 4, 2, 16'hCAFE, 1'b1);
        chk("stall_out", {16'd0, out}, 32'h0000CAFE);
        chk("stall_err", {31'd0, err}, 32'd0);

        mem_rsp_valid = 1'b1; mem_rsp_data = 16'h5555;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("stray_rsp_no_done", {31'd0, done}, 32'd0);
        end
        mem_rsp_valid = 1'b0; mem_rsp_data = 16'h0000;

        run_load(16'h0042, 2'b01, 1'b0, 0, 0, 16'h7FFE, 1'b0);
        start = 1'b1; addr_in = 16'h0042; size = 2'b01; sign_ext = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; mem_req_ready = 1'b1;
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
        chk("pre_reset_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_done", {31'd0, done}, 32'd0);
        chk("mid_rst_out", {16'd0, out}, 32'd0);
        chk("mid_rst_err", {31'd0, err}, 32'd0);
        chk("mid_rst_req_valid", {31'd0, mem_req_valid}, 32'd0);
        chk("mid_rst_mem_addr", {16'd0, mem_addr}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        mem_rsp_valid = 1'b1; mem_rsp_data = 16'h4321;
        @(posedge clk); #1;
        mem_rsp_valid = 1'b0; mem_rsp_data = 16'h0000;
        for (int k = 0; k < 3; k++) begin
            chk("late_rsp_no_done", {31'd0, done}, 32'd0);
            chk("late_rsp_idle", {31'd0, busy}, 32'd0);
            @(posedge clk); #1;
        end

        run_load(16'h0041, 2'b00, 1'b1, 0, 0, 16'h7F00, 1'b0);
        chk("after_reset_out", {16'd0, out}, 32'h0000007F);

`ifdef LOAD_TIMEOUT_EN
        chk("model_timeout_latency", m_latency(0, -1), 32'd12);
        run_load(16'h0040, 2'b10, 1'b0, 0, -1, 16'h0000, 1'b0);
        chk("timeout_err", {31'd0, err}, 32'd1);
        chk("timeout_out", {16'd0, out}, 32'd0);
        run_load(16'h0040, 2'b10, 1'b0, 0, 9, 16'h1357, 1'b0);
        chk("edge_rsp_err", {31'd0, err}, 32'd0);
        chk("edge_rsp_out", {16'd0, out}, 32'h00001357);
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/load_unit_mc.md
Name: load_unit_mc

Overview:
- Multi-cycle, parametrised register-to-value load unit for the datapath.
- Takes a base address from a register operand and issues one read to the data memory through a valid/ready request channel.
- Waits a variable number of cycles for the response, then extracts a byte, half or full word, zero- or sign-extends it, and returns it with a one-cycle done pulse.
- Sits between the register-file read port and the data-memory port; the pipeline stalls while busy is high.

Parameters:
- DATA_W, 16: memory word and result width; power of two, >= 16.
- ADDR_W, 16: byte address width.
- TIMEOUT_CYC, 255: maximum response wait in cycles. Used only when LOAD_TIMEOUT_EN is defined.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous assert, active low.
- start  in  1  load request, sampled in IDLE only.
- addr_in  in  ADDR_W  byte address (register A value).
- size  in  2  access size: 00 byte, 01 half, 10 full word, 11 reserved.
- sign_ext  in  1  1 = sign-extend, 0 = zero-extend.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse; out and err are valid in that cycle.
- out  out  DATA_W  extended load result.
- err  out  1  misaligned, reserved size, or timeout.
- mem_req_valid  out  1  read request valid.
- mem_req_ready  in  1  memory accepts the request.
- mem_addr  out  ADDR_W  word-aligned address: addr_in with the low log2(DATA_W/8) bits cleared.
- mem_rsp_valid  in  1  read data valid.
- mem_rsp_data  in  DATA_W  read data word.

Behaviour:
- Reset values: all outputs 0; state IDLE; captured address, size and sign_ext registers 0.
- States and transitions:
  - IDLE: on start=1, capture addr_in, size and sign_ext.
    - If the access is illegal, go to DONE with err=1; no memory request is issued.
    - Otherwise go to REQ.
  - Illegal access: size=11, half with lane not a multiple of 2, or full word with lane != 0.
  - REQ: mem_req_valid=1 with mem_addr stable. On mem_req_valid && mem_req_ready, go to WAIT.
  - WAIT: on mem_rsp_valid=1, latch the extracted result into out and go to DONE.
  - DONE: done=1 for exactly one cycle, then go to IDLE. out and err hold their values until the next done.
- Latency: with ready and response both immediate, start at cycle N gives done at cycle N+3 (REQ at N+1, WAIT at N+2, DONE at N+3).
  - An illegal access gives done at N+1.
- Byte lanes:
  - Little-endian; lane = addr_in[log2(DATA_W/8)-1:0].
  - Byte result = mem_rsp_data[8*lane +: 8].
  - Half result = mem_rsp_data[8*lane +: 16].
  - The selected field is extended to DATA_W: MSB replicated when sign_ext=1, zeros when 0.
  - Full word is passed through; sign_ext is ignored.
- Response ordering: mem_rsp_valid arriving in the same cycle as the request handshake is ignored. Memory must return data no earlier than the cycle after acceptance.
- Stray traffic: mem_rsp_valid in IDLE, REQ or DONE is ignored. start while busy is ignored; requests are not queued.
- Back-to-back: a start sampled in the cycle after DONE (IDLE) is accepted normally.
- Reset mid-operation: immediate return to IDLE with all outputs 0. Any late response from memory is then ignored.
- busy = (state != IDLE), decoded combinationally from the state register.
- mem_req_valid is driven from the state register, so it has no combinational path from inputs.

Optional Feature:
- Macro: LOAD_TIMEOUT_EN.
- Defined:
  - An 8+ bit counter clears on entry to REQ and increments every cycle in REQ or WAIT.
  - When the count reaches TIMEOUT_CYC, go to DONE with err=1 and out=0; mem_req_valid drops.
  - A response arriving in the cycle the count reaches TIMEOUT_CYC wins: data is taken and err=0.
- Not defined: no counter; REQ and WAIT wait indefinitely.

Test Plan (DATA_W=16):
- Full-word load: addr_in=0x0040, size=10, ready=1, response 0xBEEF one cycle after acceptance -> mem_addr=0x0040; done 3 cycles after start; out=0xBEEF, err=0.
- Byte sign extension: addr_in=0x0041, size=00, sign_ext=1, data 0x80FF -> mem_addr=0x0040, out=0xFF80. Same case with sign_ext=0 -> out=0x0080.
- Illegal accesses: misaligned half addr_in=0x0043 with size=01 -> done next cycle, err=1, no mem_req_valid. size=11 -> same response.
- Stalls and stray traffic:
  - Stall: mem_req_ready low 4 cycles -> mem_req_valid and mem_addr held stable; done follows the response.
  - Stray mem_rsp_valid in IDLE -> no done.
  - start while busy -> ignored.
- Reset: rst_n low during WAIT -> all outputs 0 immediately; a response arriving after release produces no done.
- Timeout (LOAD_TIMEOUT_EN, TIMEOUT_CYC=10): no response -> done with err=1, out=0 at count 10. Response exactly at count 10 -> err=0 with that data.
